// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM state encoding,
// bus-source select codes and a small opcode-classification helper.
package alu_seq_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_TRAP = 3'd4
    } state_t;

    localparam logic [3:0] BUS_G    = 4'd8;
    localparam logic [3:0] BUS_DIN  = 4'd9;
    localparam logic [3:0] BUS_NONE = 4'd15;

    // True for the three opcodes that take the A -> G -> register path.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/alu_sequencer_onehot_decoder.sv
// One-hot register write-enable decoder.
// Ports:
//   idx    : register index (RSEL_W bits)
//   en     : write request; when low the output is all zero
//   onehot : NREGS-wide enable, zero or exactly one bit set
module onehot_decoder #(
    parameter int NREGS  = 8,
    parameter int RSEL_W = 3
) (
    input  logic [RSEL_W-1:0] idx,
    input  logic              en,
    output logic [NREGS-1:0]  onehot
);

    // Set the single bit selected by idx when a write is requested.
    always_comb begin
        onehot = {NREGS{1'b0}};
        if (en) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = {NREGS{1'b0}};
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM that sequences a 16-bit ALU datapath (A register,
// add/sub/xor unit, accumulator G) and an NREGS-entry register file over a
// shared bus. One decoded instruction is accepted per valid/ready handshake.
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   instr_valid    : instruction present on instr_op/instr_rx/instr_ry
//   instr_ready    : sequencer idle and able to accept
//   instr_op/rx/ry : opcode, destination/first operand, source/second operand
//   bus_sel        : bus source (0..NREGS-1 register, 8 G, 9 DIN, 15 none)
//   reg_wr_en      : one-hot register load enable (only in the retire cycle)
//   addsub,xor_ctrl: ALU mode lines, meaningful in T2
//   busy           : instruction in flight
//   done           : single-cycle retire pulse
//   illegal        : illegal-opcode pulse (only with ALU_SEQ_ILLEGAL_TRAP_EN)
//
// Build option ALU_SEQ_ILLEGAL_TRAP_EN: illegal opcodes pulse illegal with
// done and then park the FSM in a sticky TRAP state left only by rst.
// Without it, illegal opcodes retire as a one-cycle NOP.
//
// All outputs are registered. They are decoded from the next state and the
// next latched instruction fields, so each registered output equals the
// Moore decode of the state it accompanies, and reset clears them at once.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREGS  = 8,
    parameter int RSEL_W = 3,
    parameter int BSEL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [RSEL_W-1:0] instr_rx,
    input  logic [RSEL_W-1:0] instr_ry,
    output logic [BSEL_W-1:0] bus_sel,
    output logic [NREGS-1:0]  reg_wr_en,
    output logic              addsub,
    output logic              xor_ctrl,
    output logic              busy,
    output logic              done
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    ,
    output logic              illegal
`endif
);

    state_t              state_r;
    state_t              state_nxt;
    logic [2:0]          op_r;
    logic [2:0]          op_nxt;
    logic [RSEL_W-1:0]   rx_r;
    logic [RSEL_W-1:0]   rx_nxt;
    logic [RSEL_W-1:0]   ry_r;
    logic [RSEL_W-1:0]   ry_nxt;
    logic                accept_s;

    logic [BSEL_W-1:0]   bus_sel_nxt;
    logic                wr_req_nxt;
    logic [NREGS-1:0]    wr_en_nxt;
    logic                addsub_nxt;
    logic                xor_nxt;
    logic                done_nxt;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic                illegal_nxt;
`endif

    assign accept_s = instr_valid && (state_r == S_IDLE);

    // Next-state logic and capture of the instruction fields on acceptance.
    always_comb begin
        state_nxt = state_r;
        op_nxt    = op_r;
        rx_nxt    = rx_r;
        ry_nxt    = ry_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt = S_T1;
                    op_nxt    = instr_op;
                    rx_nxt    = instr_rx;
                    ry_nxt    = instr_ry;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_T1: begin
                if (is_alu_op(op_r)) begin
                    state_nxt = S_T2;
                end else if ((op_r == OP_MV) || (op_r == OP_MVI)) begin
                    state_nxt = S_IDLE;
                end else begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    state_nxt = S_TRAP;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
            S_T2: state_nxt = S_T3;
            S_T3: state_nxt = S_IDLE;
            S_TRAP: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                state_nxt = S_TRAP;
`else
                state_nxt = S_IDLE;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode for the state being entered, using the fields it will hold.
    always_comb begin
        bus_sel_nxt = BSEL_W'(BUS_NONE);
        wr_req_nxt  = 1'b0;
        addsub_nxt  = 1'b0;
        xor_nxt     = 1'b0;
        done_nxt    = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        illegal_nxt = 1'b0;
`endif
        case (state_nxt)
            S_T1: begin
                if (op_nxt == OP_MV) begin
                    bus_sel_nxt = {{(BSEL_W-RSEL_W){1'b0}}, ry_nxt};
                    wr_req_nxt  = 1'b1;
                    done_nxt    = 1'b1;
                end else if (op_nxt == OP_MVI) begin
                    bus_sel_nxt = BSEL_W'(BUS_DIN);
                    wr_req_nxt  = 1'b1;
                    done_nxt    = 1'b1;
                end else if (is_alu_op(op_nxt)) begin
                    // First operand onto the bus; A captures it at end of T1.
                    bus_sel_nxt = {{(BSEL_W-RSEL_W){1'b0}}, rx_nxt};
                end else begin
                    done_nxt    = 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    illegal_nxt = 1'b1;
`endif
                end
            end
            S_T2: begin
                bus_sel_nxt = {{(BSEL_W-RSEL_W){1'b0}}, ry_nxt};
                addsub_nxt  = (op_nxt == OP_SUB);
                xor_nxt     = (op_nxt == OP_XOR);
            end
            S_T3: begin
                bus_sel_nxt = BSEL_W'(BUS_G);
                wr_req_nxt  = 1'b1;
                done_nxt    = 1'b1;
            end
            default: begin
                bus_sel_nxt = BSEL_W'(BUS_NONE);
            end
        endcase
    end

    onehot_decoder #(
        .NREGS  (NREGS),
        .RSEL_W (RSEL_W)
    ) u_wr_dec (
        .idx    (rx_nxt),
        .en     (wr_req_nxt),
        .onehot (wr_en_nxt)
    );

    // State, latched instruction fields and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            op_r        <= 3'b000;
            rx_r        <= {RSEL_W{1'b0}};
            ry_r        <= {RSEL_W{1'b0}};
            bus_sel     <= BSEL_W'(BUS_NONE);
            reg_wr_en   <= {NREGS{1'b0}};
            addsub      <= 1'b0;
            xor_ctrl    <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            instr_ready <= 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            illegal     <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt;
            op_r        <= op_nxt;
            rx_r        <= rx_nxt;
            ry_r        <= ry_nxt;
            bus_sel     <= bus_sel_nxt;
            reg_wr_en   <= wr_en_nxt;
            addsub      <= addsub_nxt;
            xor_ctrl    <= xor_nxt;
            done        <= done_nxt;
            busy        <= (state_nxt != S_IDLE);
            instr_ready <= (state_nxt == S_IDLE);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            illegal     <= illegal_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. A simple bench-side datapath
// (register file, A, G, bus mux) is driven by the sequencer's controls; a
// reference model computes register results with plain arithmetic and the
// expected control pattern per cycle from the instruction type.
module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [2:0]  instr_rx;
    logic [2:0]  instr_ry;
    logic [3:0]  bus_sel;
    logic [7:0]  reg_wr_en;
    logic        addsub;
    logic        xor_ctrl;
    logic        busy;
    logic        done;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rx    (instr_rx),
        .instr_ry    (instr_ry),
        .bus_sel     (bus_sel),
        .reg_wr_en   (reg_wr_en),
        .addsub      (addsub),
        .xor_ctrl    (xor_ctrl),
        .busy        (busy),
        .done        (done)
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side datapath.
    logic [15:0] din;
    logic [15:0] rf [8];
    logic [15:0] a_reg;
    logic [15:0] g_reg;
    logic [15:0] bus;
    int          done_cnt = 0;

    always_comb begin
        bus = 16'h0000;
        if (bus_sel < 4'd8)       bus = rf[bus_sel[2:0]];
        else if (bus_sel == 4'd8) bus = g_reg;
        else if (bus_sel == 4'd9) bus = din;
        else                      bus = 16'h0000;
    end

    always @(posedge clk) begin
        a_reg <= bus;
        g_reg <= xor_ctrl ? (a_reg ^ bus) : (addsub ? (a_reg - bus) : (a_reg + bus));
        for (int i = 0; i < 8; i++) if (reg_wr_en[i]) rf[i] <= bus;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Reference register contents.
    logic [15:0] model_rf [8];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one instruction and check every cycle until it retires.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                             input logic [15:0] d, input bit hold);
        int          lat;
        int          guard;
        bit          alu;
        logic [3:0]  e_bus;
        logic [7:0]  e_wr;
        logic        e_add, e_xor, e_done;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
        lat = alu ? 3 : 1;
        din = d;
        instr_valid = 1'b1; instr_op = op; instr_rx = rx; instr_ry = ry;
        guard = 0;
        while (instr_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                instr_valid = hold;
                instr_op = 3'($urandom); instr_rx = 3'($urandom); instr_ry = 3'($urandom);
            end
            e_bus = 4'd15; e_wr = 8'd0; e_add = 1'b0; e_xor = 1'b0; e_done = 1'b0;
            if (!alu) begin
                e_done = 1'b1;
                if (op == 3'd0)      begin e_bus = {1'b0, ry}; e_wr = 8'd1 << rx; end
                else if (op == 3'd1) begin e_bus = 4'd9;       e_wr = 8'd1 << rx; end
            end else if (c == 1) begin
                e_bus = {1'b0, rx};
            end else if (c == 2) begin
                e_bus = {1'b0, ry}; e_add = (op == 3'd3); e_xor = (op == 3'd4);
            end else begin
                e_bus = 4'd8; e_wr = 8'd1 << rx; e_done = 1'b1;
            end
            check_eq("bus_sel",   32'(bus_sel),   32'(e_bus));
            check_eq("reg_wr_en", 32'(reg_wr_en), 32'(e_wr));
            check_eq("addsub",    32'(addsub),    32'(e_add));
            check_eq("xor_ctrl",  32'(xor_ctrl),  32'(e_xor));
            check_eq("done",      32'(done),      32'(e_done));
            check_eq("busy",      32'(busy),      32'd1);
            check_eq("ready_busy",32'(instr_ready), 32'd0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            check_eq("illegal_quiet", 32'(illegal), 32'd0);
`endif
        end
        @(negedge clk);
        check_eq("ready_after", 32'(instr_ready), 32'd1);
        check_eq("busy_after",  32'(busy),        32'd0);
        check_eq("done_after",  32'(done),        32'd0);
        case (op)
            3'd0: model_rf[rx] = model_rf[ry];
            3'd1: model_rf[rx] = d;
            3'd2: model_rf[rx] = model_rf[rx] + model_rf[ry];
            3'd3: model_rf[rx] = model_rf[rx] - model_rf[ry];
            3'd4: model_rf[rx] = model_rf[rx] ^ model_rf[ry];
            default: ;
        endcase
        check_eq("rf_dest", 32'(rf[rx]), 32'(model_rf[rx]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        logic [2:0] rop;
        rst = 1'b1; instr_valid = 1'b0; instr_op = 3'd0; instr_rx = 3'd0; instr_ry = 3'd0;
        din = 16'h0000;
        for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;

        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_bus_sel", 32'(bus_sel),   32'd15);
        check_eq("rst_wr_en",   32'(reg_wr_en), 32'd0);
        check_eq("rst_addsub",  32'(addsub),    32'd0);
        check_eq("rst_xor",     32'(xor_ctrl),  32'd0);
        check_eq("rst_done",    32'(done),      32'd0);
        check_eq("rst_busy",    32'(busy),      32'd0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        check_eq("rst_illegal", 32'(illegal),   32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", 32'(instr_ready), 32'd1);

        // Fill the register file.
        for (int i = 0; i < 8; i++) run_instr(3'd1, 3'(i), 3'd0, 16'($urandom), 1'b0);

        // MVI R4 <- 0x00A5.
        run_instr(3'd1, 3'd4, 3'd0, 16'h00A5, 1'b0);
        check_eq("mvi_r4", 32'(rf[4]), 32'h00A5);

        // ADD R0,R1 with R0=5, R1=7.
        run_instr(3'd1, 3'd0, 3'd0, 16'd5, 1'b0);
        run_instr(3'd1, 3'd1, 3'd0, 16'd7, 1'b0);
        run_instr(3'd2, 3'd0, 3'd1, 16'h0000, 1'b0);
        check_eq("add_r0", 32'(rf[0]), 32'd12);

        // SUB R2,R3 then XOR R3,R3.
        run_instr(3'd1, 3'd2, 3'd0, 16'd3, 1'b0);
        run_instr(3'd1, 3'd3, 3'd0, 16'd10, 1'b0);
        run_instr(3'd3, 3'd2, 3'd3, 16'h0000, 1'b0);
        check_eq("sub_r2", 32'(rf[2]), 32'hFFF9);
        run_instr(3'd4, 3'd3, 3'd3, 16'h0000, 1'b0);
        check_eq("xor_r3", 32'(rf[3]), 32'd0);

        // Back-to-back with instr_valid held: MV R5,R0 then ADD R5,R5.
        dc0 = done_cnt;
        run_instr(3'd0, 3'd5, 3'd0, 16'h0000, 1'b1);
        run_instr(3'd2, 3'd5, 3'd5, 16'h0000, 1'b0);
        check_eq("b2b_r5", 32'(rf[5]), 32'd24);
        check_eq("b2b_done_cnt", 32'(done_cnt - dc0), 32'd2);

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            instr_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            rop = 3'($urandom_range(0, 4));
`else
            rop = 3'($urandom_range(0, 7));
`endif
            run_instr(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      16'($urandom), 1'($urandom_range(0, 1)));
        end
        instr_valid = 1'b0;
        @(negedge clk);

        // Reset asserted mid-T2 of SUB R1,R2.
        run_instr(3'd1, 3'd1, 3'd0, 16'h1234, 1'b0);
        run_instr(3'd1, 3'd2, 3'd0, 16'h0042, 1'b0);
        dc0 = done_cnt;
        instr_valid = 1'b1; instr_op = 3'd3; instr_rx = 3'd1; instr_ry = 3'd2;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check_eq("t2_addsub", 32'(addsub), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_bus_sel", 32'(bus_sel),   32'd15);
        check_eq("mid_rst_wr_en",   32'(reg_wr_en), 32'd0);
        check_eq("mid_rst_addsub",  32'(addsub),    32'd0);
        check_eq("mid_rst_busy",    32'(busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_ready", 32'(instr_ready), 32'd1);
        check_eq("post_rst_no_done", 32'(done_cnt - dc0), 32'd0);
        check_eq("post_rst_r1", 32'(rf[1]), 32'h1234);

        // Illegal opcode 3'b111.
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        instr_valid = 1'b1; instr_op = 3'b111; instr_rx = 3'd6; instr_ry = 3'd1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        check_eq("ill_illegal", 32'(illegal),   32'd1);
        check_eq("ill_done",    32'(done),      32'd1);
        check_eq("ill_wr_en",   32'(reg_wr_en), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            instr_valid = 1'b1;
            check_eq("trap_ready",   32'(instr_ready), 32'd0);
            check_eq("trap_busy",    32'(busy),        32'd1);
            check_eq("trap_done",    32'(done),        32'd0);
            check_eq("trap_illegal", 32'(illegal),     32'd0);
            check_eq("trap_wr_en",   32'(reg_wr_en),   32'd0);
            check_eq("trap_bus_sel", 32'(bus_sel),     32'd15);
        end
        instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("trap_exit_ready", 32'(instr_ready), 32'd1);
        check_eq("trap_exit_busy",  32'(busy),        32'd0);
`else
        dc0 = done_cnt;
        run_instr(3'b111, 3'd6, 3'd1, 16'h0000, 1'b0);
        check_eq("ill_done_cnt", 32'(done_cnt - dc0), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control FSM that sequences the 16-bit ALU (A register, add/sub/xor unit, accumulator G) and the 8-entry register file over the shared bus.
- Accepts one decoded instruction per valid/ready handshake.
- Drives the bus-source select, the ALU mode lines (addsub, xor_ctrl) and the one-hot register write enables.
- Pulses done when the instruction retires.
- Sits between the instruction fetch/decode stage and the ALU datapath.

Parameters:
- NREGS, 8, number of general registers; the write-enable vector width.
- RSEL_W, 3, register index width (log2 NREGS).
- BSEL_W, 4, bus_sel width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction present on instr_op/instr_rx/instr_ry.
- instr_ready  output  1  sequencer can accept an instruction.
- instr_op  input  3  opcode: 000 MV, 001 MVI, 010 ADD, 011 SUB, 100 XOR, 101-111 illegal.
- instr_rx  input  RSEL_W  destination register, and first ALU operand.
- instr_ry  input  RSEL_W  source register, and second ALU operand.
- bus_sel  output  BSEL_W  bus source: 0..NREGS-1 = register, 8 = G (accumulator), 9 = DIN, 15 = none (bus driven 0).
- reg_wr_en  output  NREGS  one-hot register load enable.
- addsub  output  1  ALU subtract select; valid in T2.
- xor_ctrl  output  1  ALU xor select; valid in T2.
- busy  output  1  an instruction is in flight.
- done  output  1  single-cycle retire pulse.
- illegal  output  1  illegal-opcode pulse; exists only with ALU_SEQ_ILLEGAL_TRAP_EN.

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - bus_sel = 15; reg_wr_en = 0; addsub = 0; xor_ctrl = 0; done = 0; busy = 0; illegal = 0.
  - instr_ready = 1 once rst deasserts.
- Reset mid-instruction aborts immediately. No register write occurs after reset assertion, and no done is issued for the aborted instruction.
- instr_ready = (state == IDLE).
- Acceptance happens on a rising edge with instr_valid && instr_ready. op/rx/ry are latched into internal registers at that edge; later changes to the instr_* inputs are ignored until the next acceptance.
- States: IDLE, T1, T2, T3. Outputs are Moore, decoded from the state and the latched fields. Defaults: bus_sel = 15, reg_wr_en = 0, addsub = 0, xor_ctrl = 0.
- IDLE: accept -> T1.
- T1:
  - MV: bus_sel = ry, reg_wr_en[rx] = 1, done = 1 -> IDLE.
  - MVI: bus_sel = 9, reg_wr_en[rx] = 1, done = 1 -> IDLE.
  - ADD/SUB/XOR: bus_sel = rx. The A register captures the bus at the end of T1. -> T2.
  - Illegal op: done = 1, no write -> IDLE.
- T2:
  - bus_sel = ry.
  - addsub = 1 for SUB only; xor_ctrl = 1 for XOR only.
  - The accumulator captures the result at the end of T2. -> T3.
- T3: bus_sel = 8, reg_wr_en[rx] = 1, done = 1 -> IDLE.
- Latency from the acceptance edge:
  - MV/MVI/illegal: done in the 1st cycle after acceptance.
  - ALU ops: done in the 3rd cycle after acceptance.
  - instr_ready returns the cycle after done. There is no back-to-back overlap.
- busy = 1 in T1/T2/T3, 0 in IDLE.
- rx == ry is legal. ADD R3,R3 doubles R3; SUB R3,R3 yields 0; XOR R3,R3 yields 0.
- reg_wr_en is always zero or one-hot. It is never asserted outside the retire cycle.
- instr_valid held high while busy is not an error. The instruction is accepted on the first IDLE cycle.

Optional Feature:
- Macro ALU_SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - Port illegal exists.
  - Illegal opcodes pulse illegal = 1 together with done in T1.
  - The sequencer then enters a sticky TRAP state: instr_ready = 0, busy = 1, all enables 0.
  - Only rst exits TRAP.
- Undefined:
  - No illegal port and no TRAP state.
  - Illegal opcodes retire as a 1-cycle NOP, as described under Behaviour.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_XOR;
  - state encodings S_IDLE, S_T1, S_T2, S_T3, S_TRAP;
  - bus-select constants BUS_G = 8, BUS_DIN = 9, BUS_NONE = 15.
- One sub-module, onehot_decoder: maps RSEL_W index plus enable to an NREGS one-hot write enable.

Test Plan:
- Reset: assert rst mid-T2 of SUB R1,R2 -> in the same cycle reg_wr_en = 0, bus_sel = 15, done never pulses; after release instr_ready = 1 and R1 is unchanged.
- MVI R4 with DIN = 16'h00A5, accepted at edge N -> cycle N+1: bus_sel = 9, reg_wr_en = 8'b0001_0000, done = 1; R4 = 16'h00A5; instr_ready = 1 at N+2.
- R0 = 5, R1 = 7, ADD R0,R1 -> bus_sel 0, 1, 8 on three successive cycles; addsub = 0 and xor_ctrl = 0 in T2; reg_wr_en[0] and done in T3; R0 = 12.
- R2 = 3, R3 = 10, SUB R2,R3 -> addsub = 1 in T2 only; R2 = 16'hFFF9. Then XOR R3,R3 -> xor_ctrl = 1 in T2 only; R3 = 0.
- Back-to-back: MV R5,R0 then ADD R5,R5 with instr_valid held high -> second instruction accepted on the edge after the first done; R5 = 2*R0; exactly two done pulses.
- op = 3'b111:
  - Without the macro: done pulse 1 cycle after acceptance, reg_wr_en = 0, return to IDLE.
  - With ALU_SEQ_ILLEGAL_TRAP_EN: illegal = 1 and done = 1 in the same cycle, then instr_ready stays 0 until rst.
